alarm_bank: RTL and testbench
=============================

// Module: alarm_bank
// PURPOSE
//  N-channel alarm engine, successor to the single fixed alarm: per-channel hour/minute
//  setpoints, arm flags, ring timeout and button-driven editing. Sits beside current_time:
//  consumes its 1 Hz tick and time fields, drives `do` (music start) and the edit fields
//  shown on the seven-segment display.
// PARAMETERS
//  N_ALARM    4    number of alarm channels (1..16)
//  CH_W       2    channel index width, = max(1,$clog2(N_ALARM))
//  RING_SECS  60   seconds a ring lasts before auto-stop (1..255)
//  SNOOZE_SECS 300 snooze delay in seconds (1..1023; used only with ALARM_SNOOZE_EN)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous active-low reset
//  tick_1hz   in   1     one-clk pulse per second, aligned with current_time update
//  cur_hour   in   5     current hour 0..23
//  cur_min    in   6     current minute 0..59
//  cur_sec    in   6     current second 0..59
//  edit_en    in   1     high while the alarm mode is selected
//  btn_up     in   1     one-clk pulse, debounced upstream
//  btn_down   in   1     one-clk pulse
//  btn_mid    in   1     one-clk pulse
//  ring       out  1     high while any channel rings (drives `do`)
//  ring_ch    out  CH_W  lowest-index ringing channel; 0 when idle
//  armed      out  N_ALARM  per-channel arm flags
//  edit_field out  2     0 SEL_CH, 1 SET_HR, 2 SET_MIN, 3 SET_ARM
//  edit_ch    out  CH_W  channel under edit
//  disp_hour  out  5     setpoint hour of edit_ch
//  disp_min   out  6     setpoint minute of edit_ch
// BEHAVIOUR
//  Reset: all setpoints 00:00, armed=0, ring=0, ring_ch=0, edit_field=0, edit_ch=0,
//   ring/snooze counters 0. All outputs registered; 1-clk latency from input pulse.
//  Edit FSM (active only when edit_en=1; all transitions on btn pulses):
//   SEL_CH: up/down inc/dec edit_ch, wraps N_ALARM-1<->0; mid -> SET_HR.
//   SET_HR: up/down mod 24 (23->0, 0->23); mid -> SET_MIN.
//   SET_MIN: up/down mod 60; mid -> SET_ARM.
//   SET_ARM: up or down toggles armed[edit_ch]; mid -> SEL_CH.
//   edit_en falling: FSM returns to SEL_CH at once; edited values are kept.
//   Simultaneous up+down in one clk: no change. Editing a channel clears its ring.
//  Match: on tick_1hz, channel i triggers if armed[i] and cur_hour/cur_min equal setpoint
//   and cur_sec==0. Trigger loads ring counter[i]=RING_SECS; ring[i] while counter!=0;
//   counter decrements on each tick_1hz. Multiple channels may ring together.
//  Dismiss (edit_en=0): btn_mid clears all ringing channels; arm flags unchanged.
//   btn_up/down with edit_en=0 and no snooze build: ignored.
//  Trigger and dismiss in the same clk: trigger wins (ring starts).
//  A channel re-triggers only at its next matching minute (once per day).
//  Reset mid-ring or mid-edit: immediate return to reset state, no pending pulses.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: btn_up with edit_en=0 while ringing moves each ringing
//   channel to snooze: ring cleared, snooze counter[i]=SNOOZE_SECS, decremented per tick;
//   reaching 0 reloads ring counter (re-ring). btn_mid also cancels pending snoozes.
//   Disarming a channel cancels its snooze.
//  Not defined: no snooze counters/logic are synthesised; btn_up outside edit is ignored.
// TESTING
//  Reset, set ch1=07:30 armed via SEL_CH/HR/MIN/ARM -> armed=4'b0010, disp 07:30.
//  Time 07:30:00 tick -> next clk ring=1, ring_ch=1; after 60 ticks ring=0.
//  SET_HR at 23, btn_up -> 0; SET_MIN at 0, btn_down -> 59; SEL_CH 3 up -> 0.
//  ch0 and ch2 both 06:00 armed -> ring_ch=0; btn_mid -> ring=0 both cleared.
//  SNOOZE_EN: ringing, btn_up -> ring=0; 300 ticks later ring=1 again, same ch.
//  Assert rst_n low mid-ring -> ring=0, armed=0 asynchronously, before next clk edge.

Source files
------------

// File: rtl/alarm_bank.sv
// N-channel alarm engine: per-channel setpoints, arm flags, ring timeout and button-driven edit FSM.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_bank #(
    parameter int N_ALARM     = 4,
    parameter int CH_W        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_1hz,
    input  logic [4:0]          cur_hour,
    input  logic [5:0]          cur_min,
    input  logic [5:0]          cur_sec,
    input  logic                edit_en,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_mid,
    output logic                ring,
    output logic [CH_W-1:0]     ring_ch,
    output logic [N_ALARM-1:0]  armed,
    output logic [1:0]          edit_field,
    output logic [CH_W-1:0]     edit_ch,
    output logic [4:0]          disp_hour,
    output logic [5:0]          disp_min
);

    localparam int RING_W = 8;
    localparam int SNZ_W  = 10;
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_ALARM - 1);

    typedef enum logic [1:0] {SEL_CH = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_ARM = 2'd3} field_e;

    field_e               state_q, state_d;
    logic [CH_W-1:0]      edit_ch_q, edit_ch_d;
    logic [N_ALARM-1:0]   armed_q, armed_d;
    logic [4:0]           hour_q [N_ALARM];
    logic [4:0]           hour_d [N_ALARM];
    logic [5:0]           min_q  [N_ALARM];
    logic [5:0]           min_d  [N_ALARM];
    logic [RING_W-1:0]    ring_cnt_q [N_ALARM];
    logic [RING_W-1:0]    ring_cnt_d [N_ALARM];
    logic                 ring_q, ring_d;
    logic [CH_W-1:0]      ring_ch_q, ring_ch_d;
    logic [4:0]           disp_hour_q, disp_hour_d;
    logic [5:0]           disp_min_q, disp_min_d;

    logic step_up, step_dn, edit_act, dismiss;
    logic [N_ALARM-1:0]   trig;

    assign step_up  = btn_up & ~btn_down;
    assign step_dn  = btn_down & ~btn_up;
    assign edit_act = edit_en & ~btn_mid & (step_up | step_dn);
    assign dismiss  = ~edit_en & btn_mid;

    always_comb begin
        for (int i = 0; i < N_ALARM; i++) begin
            trig[i] = tick_1hz && armed_q[i] && (cur_hour == hour_q[i]) &&
                      (cur_min == min_q[i]) && (cur_sec == 6'd0);
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0] snz_cnt_q [N_ALARM];
    logic [SNZ_W-1:0] snz_cnt_d [N_ALARM];
    logic             snooze_req;
    assign snooze_req = ~edit_en & btn_up & ring_q;
`endif

    // Edit FSM: state register / next state / outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEL_CH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!edit_en) begin
            state_d = SEL_CH;
        end else if (btn_mid) begin
            case (state_q)
                SEL_CH:  state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_ARM;
                default: state_d = SEL_CH;
            endcase
        end
    end

    always_comb begin
        edit_field = state_q;
    end

    // NOTE: combinational blocks use blocking '=' with every target defaulted first, so later
    // statements in the same block see earlier updates and no latch can be inferred.
    always_comb begin
        edit_ch_d   = edit_ch_q;
        armed_d     = armed_q;
        hour_d      = hour_q;
        min_d       = min_q;
        ring_cnt_d  = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d   = snz_cnt_q;
`endif
        if (edit_act) begin
            case (state_q)
                SEL_CH: begin
                    if (step_up) edit_ch_d = (edit_ch_q == CH_MAX) ? '0 : edit_ch_q + CH_W'(1);
                    else         edit_ch_d = (edit_ch_q == '0) ? CH_MAX : edit_ch_q - CH_W'(1);
                end
                SET_HR: begin
                    if (step_up) hour_d[edit_ch_q] = (hour_q[edit_ch_q] == 5'd23) ? 5'd0 : hour_q[edit_ch_q] + 5'd1;
                    else         hour_d[edit_ch_q] = (hour_q[edit_ch_q] == 5'd0) ? 5'd23 : hour_q[edit_ch_q] - 5'd1;
                end
                SET_MIN: begin
                    if (step_up) min_d[edit_ch_q] = (min_q[edit_ch_q] == 6'd59) ? 6'd0 : min_q[edit_ch_q] + 6'd1;
                    else         min_d[edit_ch_q] = (min_q[edit_ch_q] == 6'd0) ? 6'd59 : min_q[edit_ch_q] - 6'd1;
                end
                default: armed_d[edit_ch_q] = ~armed_q[edit_ch_q];
            endcase
            if (state_q != SEL_CH) ring_cnt_d[edit_ch_q] = '0;
        end

        // Later statements take priority: a trigger always overrides dismiss or snooze.
        for (int i = 0; i < N_ALARM; i++) begin
            if (tick_1hz && ring_cnt_d[i] != '0) ring_cnt_d[i] = ring_cnt_d[i] - RING_W'(1);
`ifdef ALARM_SNOOZE_EN
            if (tick_1hz && snz_cnt_q[i] != '0) begin
                snz_cnt_d[i] = snz_cnt_q[i] - SNZ_W'(1);
                if (snz_cnt_q[i] == SNZ_W'(1)) ring_cnt_d[i] = RING_W'(RING_SECS);
            end
            if (snooze_req && ring_cnt_q[i] != '0) begin
                snz_cnt_d[i]  = SNZ_W'(SNOOZE_SECS);
                ring_cnt_d[i] = '0;
            end
            if (dismiss || !armed_d[i]) snz_cnt_d[i] = '0;
`endif
            if (dismiss) ring_cnt_d[i] = '0;
            if (trig[i]) ring_cnt_d[i] = RING_W'(RING_SECS);
        end

        ring_d    = 1'b0;
        ring_ch_d = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (ring_cnt_d[i] != '0) begin
                ring_d    = 1'b1;
                ring_ch_d = CH_W'(i);
            end
        end
        disp_hour_d = hour_d[edit_ch_d];
        disp_min_d  = min_d[edit_ch_d];
    end

    // NOTE: the setpoint and counter arrays are reset explicitly because reset must restore
    // 00:00 on every channel; these are flops, not RAM, so a per-entry reset is legitimate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_ch_q   <= '0;
            armed_q     <= '0;
            ring_q      <= 1'b0;
            ring_ch_q   <= '0;
            disp_hour_q <= '0;
            disp_min_q  <= '0;
            for (int i = 0; i < N_ALARM; i++) begin
                hour_q[i]     <= '0;
                min_q[i]      <= '0;
                ring_cnt_q[i] <= '0;
            end
        end else begin
            edit_ch_q   <= edit_ch_d;
            armed_q     <= armed_d;
            ring_q      <= ring_d;
            ring_ch_q   <= ring_ch_d;
            disp_hour_q <= disp_hour_d;
            disp_min_q  <= disp_min_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARM; i++) snz_cnt_q[i] <= '0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
        end
    end
`endif

    assign ring      = ring_q;
    assign ring_ch   = ring_ch_q;
    assign armed     = armed_q;
    assign edit_ch   = edit_ch_q;
    assign disp_hour = disp_hour_q;
    assign disp_min  = disp_min_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank (N_ALARM=4): directed button/tick sequences push expected
// output snapshots; a negedge monitor pops and compares them.
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       edit_en = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_mid = 1'b0;
    logic       ring;
    logic [1:0] ring_ch;
    logic [3:0] armed;
    logic [1:0] edit_field;
    logic [1:0] edit_ch;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;

    alarm_bank dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down), .btn_mid(btn_mid),
        .ring(ring), .ring_ch(ring_ch), .armed(armed), .edit_field(edit_field),
        .edit_ch(edit_ch), .disp_hour(disp_hour), .disp_min(disp_min)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {ring, ring_ch, armed, edit_field, edit_ch, disp_hour, disp_min}
    typedef struct {
        string       name;
        logic [21:0] vec;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic push(input string name, input logic r, input logic [1:0] rc, input logic [3:0] arm,
                        input logic [1:0] fld, input logic [1:0] ch, input logic [4:0] hr,
                        input logic [5:0] mn);
        exp_t e;
        e.name = name;
        e.vec  = {r, rc, arm, fld, ch, hr, mn};
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({ring, ring_ch, armed, edit_field, edit_ch, disp_hour, disp_min} === mon_e.vec) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got ring=%b ring_ch=%0d armed=%b field=%0d ch=%0d disp=%0d:%0d expected ring=%b ring_ch=%0d armed=%b field=%0d ch=%0d disp=%0d:%0d",
                         mon_e.name, ring, ring_ch, armed, edit_field, edit_ch, disp_hour, disp_min,
                         mon_e.vec[21], mon_e.vec[20:19], mon_e.vec[18:15], mon_e.vec[14:13],
                         mon_e.vec[12:11], mon_e.vec[10:6], mon_e.vec[5:0]);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic up, input logic dn, input logic mid, input logic tk);
        btn_up = up; btn_down = dn; btn_mid = mid; tick_1hz = tk;
        @(posedge clk); #1;
        btn_up = 1'b0; btn_down = 1'b0; btn_mid = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic ups(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic downs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mid();
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push("reset", 0, 0, 4'b0000, 0, 0, 0, 0);

        // Program ch1 = 07:30, armed
        edit_en = 1'b1;
        ups(1);
        push("sel_ch1", 0, 0, 4'b0000, 0, 1, 0, 0);
        mid(); ups(7);
        push("hr7", 0, 0, 4'b0000, 1, 1, 7, 0);
        mid(); ups(30);
        push("min30", 0, 0, 4'b0000, 2, 1, 7, 30);
        mid(); ups(1);
        push("arm_ch1", 0, 0, 4'b0010, 3, 1, 7, 30);
        mid();
        push("ch1_done", 0, 0, 4'b0010, 0, 1, 7, 30);
        edit_en = 1'b0;

        // Match and ring timeout
        tick(7, 29, 0);
        push("no_trig_min", 0, 0, 4'b0010, 0, 1, 7, 30);
        tick(7, 30, 5);
        push("no_trig_sec", 0, 0, 4'b0010, 0, 1, 7, 30);
        tick(7, 30, 0);
        push("trig_ch1", 1, 1, 4'b0010, 0, 1, 7, 30);
        for (int i = 1; i <= 59; i++) tick(7, 30, 6'(i));
        push("ring_59", 1, 1, 4'b0010, 0, 1, 7, 30);
        tick(7, 31, 0);
        push("ring_end", 0, 0, 4'b0010, 0, 1, 7, 30);

        // Wrap boundaries on ch1
        edit_en = 1'b1;
        mid(); downs(8);
        push("hr_0_to_23", 0, 0, 4'b0010, 1, 1, 23, 30);
        ups(1);
        push("hr_23_to_0", 0, 0, 4'b0010, 1, 1, 0, 30);
        mid(); downs(31);
        push("min_0_to_59", 0, 0, 4'b0010, 2, 1, 0, 59);
        ups(1);
        push("min_59_to_0", 0, 0, 4'b0010, 2, 1, 0, 0);
        mid(); mid();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        push("updown_nop", 0, 0, 4'b0010, 0, 1, 0, 0);
        ups(2);
        push("ch3", 0, 0, 4'b0010, 0, 3, 0, 0);
        ups(1);
        push("ch_3_to_0", 0, 0, 4'b0010, 0, 0, 0, 0);
        downs(1);
        push("ch_0_to_3", 0, 0, 4'b0010, 0, 3, 0, 0);

        // ch0 and ch2 = 06:00 armed
        ups(1); mid(); ups(6); mid(); mid(); ups(1); mid();
        ups(2); mid(); ups(6); mid(); mid(); ups(1); mid();
        push("ch2_set", 0, 0, 4'b0111, 0, 2, 6, 0);
        mid();
        push("to_set_hr", 0, 0, 4'b0111, 1, 2, 6, 0);
        edit_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        push("edit_exit", 0, 0, 4'b0111, 0, 2, 6, 0);

        tick(6, 0, 0);
        push("multi_ring", 1, 0, 4'b0111, 0, 2, 6, 0);
        mid();
        push("dismiss", 0, 0, 4'b0111, 0, 2, 6, 0);
        cur_hour = 6; cur_min = 0; cur_sec = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        push("trig_beats_dismiss", 1, 0, 4'b0111, 0, 2, 6, 0);
        mid();
        push("dismiss2", 0, 0, 4'b0111, 0, 2, 6, 0);

        // Editing ch0 clears only its ring
        tick(6, 0, 0);
        edit_en = 1'b1;
        downs(2); mid(); ups(1);
        push("edit_clears_ring", 1, 2, 4'b0111, 1, 0, 7, 0);
        downs(1); mid(); mid(); mid();
        edit_en = 1'b0;
        mid();
        push("dismiss3", 0, 0, 4'b0111, 0, 0, 6, 0);

        tick(6, 0, 0);
`ifdef ALARM_SNOOZE_EN
        ups(1);
        push("snoozed", 0, 0, 4'b0111, 0, 0, 6, 0);
        for (int i = 0; i < 299; i++) tick(6, 0, 1);
        push("snooze_299", 0, 0, 4'b0111, 0, 0, 6, 0);
        tick(6, 0, 1);
        push("re_ring", 1, 0, 4'b0111, 0, 0, 6, 0);
`else
        ups(1);
        push("up_ignored", 1, 0, 4'b0111, 0, 0, 6, 0);
        downs(1);
        push("down_ignored", 1, 0, 4'b0111, 0, 0, 6, 0);
`endif
        mid();
        push("dismiss4", 0, 0, 4'b0111, 0, 0, 6, 0);

        // Asynchronous reset mid-ring
        tick(6, 0, 0);
        push("ring_before_rst", 1, 0, 4'b0111, 0, 0, 6, 0);
        @(negedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        push("async_reset", 0, 0, 4'b0000, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        push("post_reset", 0, 0, 4'b0000, 0, 0, 0, 0);

        @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d unchecked entries expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
